id_ex_pipe: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control bits from ID, and presents them to EX.
- Its registered Rs/Rt/Rd indices and RegWr are the ID_EX inputs consumed by the downstream forwarding unit.
- Generates the one-cycle load-use stall and inserts the bubble.
- Handles branch flush and external hold.

---
 rtl/id_ex_pipe.sv | 166 ++++++++++++++++
 tb/tb_id_ex_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and hold.
// Optional macro ID_EX_HAZ_STATS_EN adds saturating load-use and flush event counters.
module id_ex_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic               iID_Valid,
    input  logic [REG_W-1:0]   iID_Rs,
    input  logic [REG_W-1:0]   iID_Rt,
    input  logic [REG_W-1:0]   iID_Rd,
    input  logic               iID_UsesRt,
    input  logic [DATA_W-1:0]  iID_RsData,
    input  logic [DATA_W-1:0]  iID_RtData,
    input  logic [DATA_W-1:0]  iID_Imm,
    input  logic               iID_RegWr,
    input  logic               iID_MemRd,
    input  logic               iID_MemWr,
    input  logic               iID_MemToReg,
    input  logic               iID_AluSrc,
    input  logic               iID_RegDst,
    input  logic [ALUOP_W-1:0] iID_AluOp,
    input  logic               iFlush,
    input  logic               iHold,
    output logic [REG_W-1:0]   oID_EX_ppRs,
    output logic [REG_W-1:0]   oID_EX_ppRt,
    output logic [REG_W-1:0]   oID_EX_ppRd,
    output logic [DATA_W-1:0]  oID_EX_ppRsData,
    output logic [DATA_W-1:0]  oID_EX_ppRtData,
    output logic [DATA_W-1:0]  oID_EX_ppImm,
    output logic               oID_EX_ppRegWr,
    output logic               oID_EX_ppMemRd,
    output logic               oID_EX_ppMemWr,
    output logic               oID_EX_ppMemToReg,
    output logic               oID_EX_ppAluSrc,
    output logic               oID_EX_ppRegDst,
    output logic [ALUOP_W-1:0] oID_EX_ppAluOp,
    output logic               oID_EX_ppValid,
    output logic               oLoadUseStall
`ifdef ID_EX_HAZ_STATS_EN
    ,
    output logic [15:0]        oStatLoadUse,
    output logic [15:0]        oStatFlush
`endif
);

    typedef struct packed {
        logic               valid;
        logic               reg_wr;
        logic               mem_rd;
        logic               mem_wr;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
    } id_ex_t;

    id_ex_t pp_q, pp_d;
    id_ex_t id_pkt, bubble_pkt;
    logic   haz;

    // A load in EX whose destination is read by the instruction in ID; $zero never conflicts.
    assign haz = pp_q.valid & pp_q.mem_rd & (pp_q.rt != '0) & iID_Valid &
                 ((pp_q.rt == iID_Rs) | (iID_UsesRt & (pp_q.rt == iID_Rt)));

    assign oLoadUseStall = haz & ~iFlush & ~iHold;

    // NOTE: every variable in this block gets a default first, so no latch can be inferred.
    always_comb begin
        id_pkt            = '0;
        id_pkt.valid      = iID_Valid;
        id_pkt.reg_wr     = iID_RegWr    & iID_Valid;
        id_pkt.mem_rd     = iID_MemRd    & iID_Valid;
        id_pkt.mem_wr     = iID_MemWr    & iID_Valid;
        id_pkt.mem_to_reg = iID_MemToReg & iID_Valid;
        id_pkt.alu_src    = iID_AluSrc   & iID_Valid;
        id_pkt.reg_dst    = iID_RegDst   & iID_Valid;
        id_pkt.alu_op     = iID_AluOp    & {ALUOP_W{iID_Valid}};
        id_pkt.rs         = iID_Rs;
        id_pkt.rt         = iID_Rt;
        id_pkt.rd         = iID_Rd;
        id_pkt.rs_data    = iID_RsData;
        id_pkt.rt_data    = iID_RtData;
        id_pkt.imm        = iID_Imm;

        // Bubble keeps the operand fields but carries no architectural effect.
        bubble_pkt            = id_pkt;
        bubble_pkt.valid      = 1'b0;
        bubble_pkt.reg_wr     = 1'b0;
        bubble_pkt.mem_rd     = 1'b0;
        bubble_pkt.mem_wr     = 1'b0;
        bubble_pkt.mem_to_reg = 1'b0;
        bubble_pkt.alu_src    = 1'b0;
        bubble_pkt.reg_dst    = 1'b0;
        bubble_pkt.alu_op     = '0;

        pp_d = pp_q;
        if (iFlush) begin
            pp_d = bubble_pkt;
        end else if (iHold) begin
            pp_d = pp_q;
        end else if (haz) begin
            pp_d = bubble_pkt;
        end else begin
            pp_d = id_pkt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            pp_q <= '0;
        end else begin
            pp_q <= pp_d;
        end
    end

    assign oID_EX_ppValid    = pp_q.valid;
    assign oID_EX_ppRegWr    = pp_q.reg_wr;
    assign oID_EX_ppMemRd    = pp_q.mem_rd;
    assign oID_EX_ppMemWr    = pp_q.mem_wr;
    assign oID_EX_ppMemToReg = pp_q.mem_to_reg;
    assign oID_EX_ppAluSrc   = pp_q.alu_src;
    assign oID_EX_ppRegDst   = pp_q.reg_dst;
    assign oID_EX_ppAluOp    = pp_q.alu_op;
    assign oID_EX_ppRs       = pp_q.rs;
    assign oID_EX_ppRt       = pp_q.rt;
    assign oID_EX_ppRd       = pp_q.rd;
    assign oID_EX_ppRsData   = pp_q.rs_data;
    assign oID_EX_ppRtData   = pp_q.rt_data;
    assign oID_EX_ppImm      = pp_q.imm;

`ifdef ID_EX_HAZ_STATS_EN
    logic [15:0] stat_load_q, stat_flush_q;
    logic        load_evt, flush_evt;

    assign load_evt  = oLoadUseStall;
    assign flush_evt = iFlush & ~iHold & (pp_q.valid | iID_Valid);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            stat_load_q  <= '0;
            stat_flush_q <= '0;
        end else begin
            if (load_evt && (stat_load_q != 16'hFFFF)) begin
                stat_load_q <= stat_load_q + 16'd1;
            end
            if (flush_evt && (stat_flush_q != 16'hFFFF)) begin
                stat_flush_q <= stat_flush_q + 16'd1;
            end
        end
    end

    assign oStatLoadUse = stat_load_q;
    assign oStatFlush   = stat_flush_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed load-use/flush/hold/reset steps plus random traffic
// against an instruction-level reference model. Honours ID_EX_HAZ_STATS_EN when defined.
module tb_id_ex_pipe;

    logic        iClk;
    logic        iReset;
    logic        iID_Valid;
    logic [4:0]  iID_Rs, iID_Rt, iID_Rd;
    logic        iID_UsesRt;
    logic [31:0] iID_RsData, iID_RtData, iID_Imm;
    logic        iID_RegWr, iID_MemRd, iID_MemWr, iID_MemToReg, iID_AluSrc, iID_RegDst;
    logic [3:0]  iID_AluOp;
    logic        iFlush, iHold;
    logic [4:0]  oID_EX_ppRs, oID_EX_ppRt, oID_EX_ppRd;
    logic [31:0] oID_EX_ppRsData, oID_EX_ppRtData, oID_EX_ppImm;
    logic        oID_EX_ppRegWr, oID_EX_ppMemRd, oID_EX_ppMemWr, oID_EX_ppMemToReg;
    logic        oID_EX_ppAluSrc, oID_EX_ppRegDst;
    logic [3:0]  oID_EX_ppAluOp;
    logic        oID_EX_ppValid;
    logic        oLoadUseStall;
`ifdef ID_EX_HAZ_STATS_EN
    logic [15:0] oStatLoadUse, oStatFlush;
`endif

    id_ex_pipe #(.DATA_W(32), .REG_W(5), .ALUOP_W(4)) dut (
        .iClk(iClk), .iReset(iReset),
        .iID_Valid(iID_Valid), .iID_Rs(iID_Rs), .iID_Rt(iID_Rt), .iID_Rd(iID_Rd),
        .iID_UsesRt(iID_UsesRt), .iID_RsData(iID_RsData), .iID_RtData(iID_RtData), .iID_Imm(iID_Imm),
        .iID_RegWr(iID_RegWr), .iID_MemRd(iID_MemRd), .iID_MemWr(iID_MemWr),
        .iID_MemToReg(iID_MemToReg), .iID_AluSrc(iID_AluSrc), .iID_RegDst(iID_RegDst),
        .iID_AluOp(iID_AluOp), .iFlush(iFlush), .iHold(iHold),
        .oID_EX_ppRs(oID_EX_ppRs), .oID_EX_ppRt(oID_EX_ppRt), .oID_EX_ppRd(oID_EX_ppRd),
        .oID_EX_ppRsData(oID_EX_ppRsData), .oID_EX_ppRtData(oID_EX_ppRtData), .oID_EX_ppImm(oID_EX_ppImm),
        .oID_EX_ppRegWr(oID_EX_ppRegWr), .oID_EX_ppMemRd(oID_EX_ppMemRd), .oID_EX_ppMemWr(oID_EX_ppMemWr),
        .oID_EX_ppMemToReg(oID_EX_ppMemToReg), .oID_EX_ppAluSrc(oID_EX_ppAluSrc),
        .oID_EX_ppRegDst(oID_EX_ppRegDst), .oID_EX_ppAluOp(oID_EX_ppAluOp),
        .oID_EX_ppValid(oID_EX_ppValid), .oLoadUseStall(oLoadUseStall)
`ifdef ID_EX_HAZ_STATS_EN
        , .oStatLoadUse(oStatLoadUse), .oStatFlush(oStatFlush)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Instruction as seen by the model: one record per pipeline slot.
    typedef struct packed {
        bit        valid;
        bit        uses_rt;
        bit        reg_wr, mem_rd, mem_wr, mem_to_reg, alu_src, reg_dst;
        bit [3:0]  alu_op;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rs_data, rt_data, imm;
    } instr_t;

    typedef enum int {K_RTYPE, K_LOAD, K_STORE, K_ADDI} kind_e;

    instr_t id_in;
    instr_t ex_m;
    int     n_pass  = 0;
    int     n_total = 0;
    int     load_cnt  = 0;
    int     flush_cnt = 0;

    function automatic instr_t mk(bit valid, kind_e kind, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        instr_t i;
        i         = '0;
        i.valid   = valid;
        i.rs      = rs;
        i.rt      = rt;
        i.rd      = rd;
        i.rs_data = $urandom;
        i.rt_data = $urandom;
        i.imm     = $urandom;
        i.alu_op  = 4'($urandom_range(1, 15));
        case (kind)
            K_RTYPE: begin i.reg_wr = 1; i.reg_dst = 1; i.uses_rt = 1; end
            K_LOAD:  begin i.reg_wr = 1; i.mem_rd = 1; i.mem_to_reg = 1; i.alu_src = 1; end
            K_STORE: begin i.mem_wr = 1; i.alu_src = 1; i.uses_rt = 1; end
            default: begin i.reg_wr = 1; i.alu_src = 1; end
        endcase
        return i;
    endfunction

    task automatic apply();
        iID_Valid    = id_in.valid;
        iID_Rs       = id_in.rs;
        iID_Rt       = id_in.rt;
        iID_Rd       = id_in.rd;
        iID_UsesRt   = id_in.uses_rt;
        iID_RsData   = id_in.rs_data;
        iID_RtData   = id_in.rt_data;
        iID_Imm      = id_in.imm;
        iID_RegWr    = id_in.reg_wr;
        iID_MemRd    = id_in.mem_rd;
        iID_MemWr    = id_in.mem_wr;
        iID_MemToReg = id_in.mem_to_reg;
        iID_AluSrc   = id_in.alu_src;
        iID_RegDst   = id_in.reg_dst;
        iID_AluOp    = id_in.alu_op;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // The load in EX produces a register that the instruction in ID reads.
    function automatic bit model_haz();
        if (!(ex_m.valid && ex_m.mem_rd) || ex_m.rt == 0 || !id_in.valid) return 0;
        return (ex_m.rt == id_in.rs) || (id_in.uses_rt && ex_m.rt == id_in.rt);
    endfunction

    task automatic model_edge();
        bit h;
        h = model_haz();
        if (!iHold) begin
            if (iFlush && (ex_m.valid || id_in.valid)) flush_cnt = (flush_cnt < 65535) ? flush_cnt + 1 : 65535;
            if (!iFlush && h) load_cnt = (load_cnt < 65535) ? load_cnt + 1 : 65535;
        end
        if (iFlush || (!iHold && h)) begin
            ex_m = '0;
        end else if (!iHold) begin
            ex_m = id_in.valid ? id_in : instr_t'('0);
        end
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".valid"},    oID_EX_ppValid,    ex_m.valid);
        check({tag, ".regwr"},    oID_EX_ppRegWr,    ex_m.reg_wr);
        check({tag, ".memrd"},    oID_EX_ppMemRd,    ex_m.mem_rd);
        check({tag, ".memwr"},    oID_EX_ppMemWr,    ex_m.mem_wr);
        check({tag, ".memtoreg"}, oID_EX_ppMemToReg, ex_m.mem_to_reg);
        check({tag, ".aluop"},    oID_EX_ppAluOp,    ex_m.alu_op);
        if (ex_m.valid) begin
            check({tag, ".alusrc"}, oID_EX_ppAluSrc, ex_m.alu_src);
            check({tag, ".regdst"}, oID_EX_ppRegDst, ex_m.reg_dst);
            check({tag, ".rs"},     oID_EX_ppRs,     ex_m.rs);
            check({tag, ".rt"},     oID_EX_ppRt,     ex_m.rt);
            check({tag, ".rd"},     oID_EX_ppRd,     ex_m.rd);
            check({tag, ".rsdata"}, oID_EX_ppRsData, ex_m.rs_data);
            check({tag, ".rtdata"}, oID_EX_ppRtData, ex_m.rt_data);
            check({tag, ".imm"},    oID_EX_ppImm,    ex_m.imm);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, ".valid"}, oID_EX_ppValid, 0);
        check({tag, ".ctrl"}, {oID_EX_ppRegWr, oID_EX_ppMemRd, oID_EX_ppMemWr, oID_EX_ppMemToReg,
                               oID_EX_ppAluSrc, oID_EX_ppRegDst, oID_EX_ppAluOp}, 0);
        check({tag, ".idx"}, {oID_EX_ppRs, oID_EX_ppRt, oID_EX_ppRd}, 0);
        check({tag, ".rsdata"}, oID_EX_ppRsData, 0);
        check({tag, ".rtdata"}, oID_EX_ppRtData, 0);
        check({tag, ".imm"}, oID_EX_ppImm, 0);
        check({tag, ".stall"}, oLoadUseStall, 0);
`ifdef ID_EX_HAZ_STATS_EN
        check({tag, ".statload"}, oStatLoadUse, 0);
        check({tag, ".statflush"}, oStatFlush, 0);
`endif
    endtask

    // One clock: entered just after a rising edge with id_in/iFlush/iHold set.
    task automatic cycle(string tag);
        apply();
        @(negedge iClk);
        check({tag, ".stall"}, oLoadUseStall, model_haz() && !iFlush && !iHold);
`ifdef ID_EX_HAZ_STATS_EN
        check({tag, ".statload"}, oStatLoadUse, load_cnt);
        check({tag, ".statflush"}, oStatFlush, flush_cnt);
`endif
        @(posedge iClk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // Reset: asynchronous, outputs zero before any edge.
        iReset = 1'b1;
        iFlush = 1'b0;
        iHold  = 1'b0;
        id_in  = '0;
        ex_m   = '0;
        apply();
        #2;
        check_zero("reset_async");
        @(posedge iClk);
        #1;
        check_zero("reset_held");
        iReset = 1'b0;

        // Load-use on Rs: lw $5 then add $7,$5,$6.
        id_in = mk(1, K_LOAD, 5'd1, 5'd5, 5'd0);
        cycle("lw5");
        id_in = mk(1, K_RTYPE, 5'd5, 5'd6, 5'd7);
        cycle("add_stall");
        check("add_bubble.valid", oID_EX_ppValid, 0);
        check("add_bubble.regwr", oID_EX_ppRegWr, 0);
        cycle("add_capture");
        check("add_capture.rs", oID_EX_ppRs, 5);
        check("add_capture.rt", oID_EX_ppRt, 6);

        // Load-use on Rt, then same indices with Rt unused (addi).
        id_in = mk(1, K_LOAD, 5'd2, 5'd9, 5'd0);
        cycle("lw9");
        id_in = mk(1, K_STORE, 5'd3, 5'd9, 5'd0);
        cycle("sw_rt_stall");
        cycle("sw_capture");
        id_in = mk(1, K_LOAD, 5'd2, 5'd9, 5'd0);
        cycle("lw9b");
        id_in = mk(1, K_ADDI, 5'd3, 5'd9, 5'd0);
        cycle("addi_nostall");

        // $zero is never a hazard.
        id_in = mk(1, K_LOAD, 5'd4, 5'd0, 5'd0);
        cycle("lw0");
        id_in = mk(1, K_RTYPE, 5'd0, 5'd0, 5'd8);
        cycle("zero_src");

        // Flush wins over a simultaneous hazard.
        id_in = mk(1, K_LOAD, 5'd1, 5'd5, 5'd0);
        cycle("lw5_flush");
        id_in = mk(1, K_STORE, 5'd5, 5'd2, 5'd0);
        iFlush = 1'b1;
        cycle("flush_haz");
        iFlush = 1'b0;
        check("flush_bubble.memwr", oID_EX_ppMemWr, 0);

        // Hold for three cycles with changing ID inputs, then release.
        id_in = mk(1, K_RTYPE, 5'd10, 5'd11, 5'd12);
        cycle("pre_hold");
        iHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_in = mk(1, K_RTYPE, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd3);
            cycle("hold");
            check("hold.rs_frozen", oID_EX_ppRs, 10);
        end
        iHold = 1'b0;
        cycle("hold_release");

        // Hold together with a hazard: no stall while held, re-evaluated afterwards.
        id_in = mk(1, K_LOAD, 5'd1, 5'd7, 5'd0);
        cycle("lw7");
        id_in = mk(1, K_RTYPE, 5'd7, 5'd1, 5'd2);
        iHold = 1'b1;
        cycle("hold_haz");
        iHold = 1'b0;
        cycle("after_hold_haz");
        cycle("after_hold_cap");

        // Random traffic with a small register set so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0 || !model_haz())
                id_in = mk($urandom_range(0, 9) != 0, kind_e'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            iFlush = ($urandom_range(0, 9) == 0);
            iHold  = ($urandom_range(0, 6) == 0);
            cycle("rand");
        end
        iFlush = 1'b0;
        iHold  = 1'b0;

        // Reset mid-operation: a live instruction vanishes between edges.
        id_in = mk(1, K_RTYPE, 5'd1, 5'd2, 5'd3);
        cycle("pre_reset");
        check("pre_reset.valid", oID_EX_ppValid, 1);
        #2;
        iReset = 1'b1;
        #1;
        ex_m = '0;
        load_cnt  = 0;
        flush_cnt = 0;
        check_zero("reset_mid");
        #2;
        iReset = 1'b0;
        @(posedge iClk);
        model_edge();
        #1;
        check_outputs("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
